// File: rtl/wordcount_reducer_if.sv
// Word-count reducer stream bundle: mapper records in, {count,key} pairs out.
// Both sides use the 64-bit valid/ready handshake.
interface wordcount_reducer_if;
   logic [63:0] io_enq_dat;
   logic        io_enq_val;
   logic        io_enq_rdy;
   logic        io_flush;
   logic [63:0] io_deq_dat;
   logic        io_deq_val;
   logic        io_deq_rdy;

   modport master (
      output io_enq_dat, io_enq_val, io_flush, io_deq_rdy,
      input  io_enq_rdy, io_deq_val, io_deq_dat
   );

   modport slave (
      input  io_enq_dat, io_enq_val, io_flush, io_deq_rdy,
      output io_enq_rdy, io_deq_val, io_deq_dat
   );
endinterface

// File: rtl/wordcount_reducer.sv
// Word-count reducer: merges equal keys in a small associative table, drains on
// flush or full. WC_REDUCER_SAT_EN selects saturating (vs wrapping) merges.
module wordcount_reducer #(
   parameter int ENTRIES = 8
) (
   input logic                clk,
   input logic                reset,
   wordcount_reducer_if.slave io
);
   localparam int AW = $clog2(ENTRIES);
   localparam int OW = AW + 1;

   typedef enum logic {ACCUM, DRAIN} state_e;

   state_e             state_q, state_d;
   logic               live_q;
   logic [ENTRIES-1:0] vld_q, vld_d;
   logic [55:0]        key_q [ENTRIES];
   logic [55:0]        key_d [ENTRIES];
   logic [7:0]         cnt_q [ENTRIES];
   logic [7:0]         cnt_d [ENTRIES];
   logic [OW-1:0]      occ_q, occ_d;
   logic [AW-1:0]      dp_q, dp_d;

   logic               acc;
   logic [4:0]         rec_cnt;
   logic [55:0]        rec_key;
   logic               hit;
   logic [AW-1:0]      hit_idx;
   logic [7:0]         upd;
   logic               unused_top;

   assign rec_cnt    = io.io_enq_dat[60:56];
   assign rec_key    = io.io_enq_dat[55:0];
   assign unused_top = ^io.io_enq_dat[63:61];

   assign io.io_enq_rdy = live_q && (state_q == ACCUM);
   assign io.io_deq_val = (state_q == DRAIN);
   assign io.io_deq_dat = (state_q == DRAIN) ?
                          {cnt_q[dp_q], key_q[dp_q]} : 64'h0;

   assign acc = io.io_enq_val && io.io_enq_rdy;

   // Keys are unique among valid slots, so at most one match fires.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (vld_q[i] && key_q[i] == rec_key) begin
            hit     = 1'b1;
            hit_idx = AW'(i);
         end
      end
   end

`ifdef WC_REDUCER_SAT_EN
   logic [8:0] sum;
   always_comb begin
      sum = {1'b0, cnt_q[hit_idx]} + {4'b0, rec_cnt};
      upd = sum[8] ? 8'hFF : sum[7:0];
   end
`else
   always_comb begin
      upd = cnt_q[hit_idx] + {3'b0, rec_cnt};
   end
`endif

   always_comb begin
      state_d = state_q;
      vld_d   = vld_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      occ_d   = occ_q;
      dp_d    = dp_q;
      unique case (state_q)
         ACCUM: begin
            if (acc) begin
               if (hit) begin
                  cnt_d[hit_idx] = upd;
               end else begin
                  vld_d[occ_q[AW-1:0]] = 1'b1;
                  key_d[occ_q[AW-1:0]] = rec_key;
                  cnt_d[occ_q[AW-1:0]] = {3'b0, rec_cnt};
                  occ_d                = occ_q + OW'(1);
               end
            end
            if (occ_d == OW'(ENTRIES)) begin
               state_d = DRAIN;
            end else if (io.io_flush && occ_d != '0) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (io.io_deq_rdy) begin
               vld_d[dp_q] = 1'b0;
               if ({1'b0, dp_q} == occ_q - OW'(1)) begin
                  occ_d   = '0;
                  dp_d    = '0;
                  state_d = ACCUM;
               end else begin
                  dp_d = dp_q + AW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ACCUM;
         live_q  <= 1'b0;
         vld_q   <= '0;
         occ_q   <= '0;
         dp_q    <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            key_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
         vld_q   <= vld_d;
         occ_q   <= occ_d;
         dp_q    <= dp_d;
         for (int i = 0; i < ENTRIES; i++) begin
            key_q[i] <= key_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end
endmodule

// File: tb/tb_wordcount_reducer.sv
// Bench for wordcount_reducer: directed records against a key/total model,
// checked every cycle, plus literal expectations per scenario.
module tb_wordcount_reducer;
   localparam int ENTRIES = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   wordcount_reducer_if io();

   wordcount_reducer #(.ENTRIES(ENTRIES)) dut (
      .clk(clk),
      .reset(reset),
      .io(io)
   );

   always #5 clk = ~clk;

   logic [55:0] m_keys[$];
   int          m_cnts[$];
   logic [63:0] out_q[$];
   bit          m_live = 1'b0;
   bit          m_drain = 1'b0;
   logic [63:0] obs[$];
   logic [63:0] lit[$];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [7:0] fold(int t);
`ifdef WC_REDUCER_SAT_EN
      return (t > 255) ? 8'hFF : t[7:0];
`else
      return t[7:0];
`endif
   endfunction

   // Model: list of distinct keys with unbounded totals; folded on drain.
   always @(negedge clk) begin
      logic [63:0] ed;
      int          idx;
      if (!reset) begin
         chk("rst_enq_rdy", 64'(io.io_enq_rdy), 64'd0);
         chk("rst_deq_val", 64'(io.io_deq_val), 64'd0);
         chk("rst_deq_dat", io.io_deq_dat, 64'd0);
         m_live = 1'b0;
         m_drain = 1'b0;
         m_keys.delete();
         m_cnts.delete();
         out_q.delete();
      end else begin
         ed = (m_drain && out_q.size() > 0) ? out_q[0] : 64'h0;
         chk("enq_rdy", 64'(io.io_enq_rdy), 64'(m_live && !m_drain));
         chk("deq_val", 64'(io.io_deq_val), 64'(m_drain));
         chk("deq_dat", io.io_deq_dat, ed);
         if (io.io_deq_val && io.io_deq_rdy) obs.push_back(io.io_deq_dat);
         if (!m_live) begin
            m_live = 1'b1;
         end else if (!m_drain) begin
            if (io.io_enq_val) begin
               idx = -1;
               foreach (m_keys[i]) if (m_keys[i] == io.io_enq_dat[55:0]) idx = i;
               if (idx >= 0) begin
                  m_cnts[idx] += int'(io.io_enq_dat[60:56]);
               end else begin
                  m_keys.push_back(io.io_enq_dat[55:0]);
                  m_cnts.push_back(int'(io.io_enq_dat[60:56]));
               end
            end
            if (m_keys.size() == ENTRIES ||
                (io.io_flush && m_keys.size() > 0)) begin
               foreach (m_keys[i]) out_q.push_back({fold(m_cnts[i]), m_keys[i]});
               m_keys.delete();
               m_cnts.delete();
               m_drain = 1'b1;
            end
         end else if (io.io_deq_rdy) begin
            void'(out_q.pop_front());
            if (out_q.size() == 0) m_drain = 1'b0;
         end
      end
   end

   task automatic send(input logic [55:0] k, input logic [4:0] c,
                       input logic [2:0] j);
      bit got = 1'b0;
      bit r;
      io.io_enq_dat = {j, c, k};
      io.io_enq_val = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         r = io.io_enq_rdy;
         @(posedge clk);
         #1;
         got = r;
      end
      io.io_enq_val = 1'b0;
      io.io_enq_dat = '0;
      chk("send_accepted", 64'(got), 64'd1);
   endtask

   task automatic flush();
      io.io_flush = 1'b1;
      @(posedge clk);
      #1;
      io.io_flush = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = io.io_enq_rdy && !io.io_deq_val;
      end
      chk("drain_done", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_obs(string nm);
      logic [63:0] g;
      chk($sformatf("%s_count", nm), 64'(obs.size()), 64'(lit.size()));
      foreach (lit[i]) begin
         g = (i < obs.size()) ? obs[i] : 64'hDEAD;
         chk($sformatf("%s[%0d]", nm, i), g, lit[i]);
      end
      obs.delete();
      lit.delete();
   endtask

   initial begin
      io.io_enq_dat = '0;
      io.io_enq_val = 1'b0;
      io.io_flush   = 1'b0;
      io.io_deq_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rdy_before_edge", 64'(io.io_enq_rdy), 64'd0);
      @(posedge clk);
      #1;
      chk("rdy_after_edge", 64'(io.io_enq_rdy), 64'd1);

      // Three identical records merge into one pair.
      repeat (3) send(56'h41, 5'd1, 3'b000);
      flush();
      wait_idle();
      lit.push_back(64'h0300000000000041);
      check_obs("t1");
      chk("t1_rdy", 64'(io.io_enq_rdy), 64'd1);

      // Interleaved keys; last record arrives together with flush.
      send(56'hA, 5'd1, 3'b000);
      send(56'hB, 5'd1, 3'b000);
      send(56'hA, 5'd1, 3'b000);
      send(56'hC, 5'd1, 3'b000);
      io.io_flush = 1'b1;
      send(56'hB, 5'd1, 3'b000);
      io.io_flush = 1'b0;
      wait_idle();
      lit.push_back({8'd2, 56'hA});
      lit.push_back({8'd2, 56'hB});
      lit.push_back({8'd1, 56'hC});
      check_obs("t2");

      // Eight distinct keys fill the table; a zero count still allocates.
      for (int i = 0; i < ENTRIES; i++) send(56'(32'h100 + i), 5'(i), 3'b000);
      chk("t3_drain_now", 64'(io.io_deq_val), 64'd1);
      chk("t3_rdy_low", 64'(io.io_enq_rdy), 64'd0);
      wait_idle();
      for (int i = 0; i < ENTRIES; i++) lit.push_back({8'(i), 56'(32'h100 + i)});
      check_obs("t3");

      // Ignored top bits, large counts.
      send(56'hDEADBEEF, 5'd31, 3'b111);
      send(56'hDEADBEEF, 5'd31, 3'b101);
      flush();
      wait_idle();
      lit.push_back({8'h3E, 56'hDEADBEEF});
      check_obs("t_big");

      // 300 hits on one key: saturate or wrap.
      repeat (300) send(56'h7, 5'd1, 3'b000);
      flush();
      wait_idle();
`ifdef WC_REDUCER_SAT_EN
      lit.push_back({8'hFF, 56'h7});
`else
      lit.push_back({8'h2C, 56'h7});
`endif
      check_obs("t4");

      // Backpressure mid-drain.
      for (int i = 1; i <= 4; i++) send(56'(8'h50 + i), 5'(i), 3'b000);
      flush();
      @(posedge clk);
      #1;
      io.io_deq_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_stall_val", 64'(io.io_deq_val), 64'd1);
         chk("t5_stall_dat", io.io_deq_dat, {8'd2, 56'h52});
      end
      @(posedge clk);
      #1;
      io.io_deq_rdy = 1'b1;
      wait_idle();
      for (int i = 1; i <= 4; i++) lit.push_back({8'(i), 56'(8'h50 + i)});
      check_obs("t5");

      // Reset in the middle of a drain discards the table.
      send(56'h61, 5'd1, 3'b000);
      send(56'h62, 5'd1, 3'b000);
      send(56'h63, 5'd1, 3'b000);
      io.io_deq_rdy = 1'b0;
      flush();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("t6_val_async", 64'(io.io_deq_val), 64'd0);
      chk("t6_dat_async", io.io_deq_dat, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      io.io_deq_rdy = 1'b1;
      @(posedge clk);
      #1;
      flush();
      repeat (5) @(posedge clk);
      #1;
      chk("t6_no_output", 64'(obs.size()), 64'd0);
      chk("t6_rdy", 64'(io.io_enq_rdy), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
